// File: rtl/char_input_queue.sv
// char_input_queue
// Upstream feeder for the 7-segment animator. Synchronises the asynchronous
// character pins, converts each rising edge of the "available" strobe into a
// single push, buffers the codes in a small FIFO and presents them one at a
// time over a valid/ready handshake.
//
// Optional feature (macro CHAR_QUEUE_OVERWRITE_EN):
//   defined   - a push while full (no pop) overwrites the oldest entry
//   undefined - a push while full is dropped
//   In both builds the sticky overflow flag is set.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   ena        block enable; low freezes all queue state
//   strobe_in  async "char available" pin; rising edge requests one push
//   char_in    async character code, stable around the strobe edge
//   out_ready  consumer accepts the head entry this cycle
//   out_valid  head entry valid (queue not empty)
//   out_char   head entry code (combinational read of the head slot)
//   full       occupancy == DEPTH
//   empty      occupancy == 0
//   count      occupancy
//   overflow   sticky: a push arrived while full
module char_input_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned CHAR_W      = 7,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     strobe_in,
    input  logic [CHAR_W-1:0]        char_in,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [CHAR_W-1:0]        out_char,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [SYNC_STAGES-1:0] s_sync;
    logic [CHAR_W-1:0]      d_sync [SYNC_STAGES];
    logic                   s_prev;

    logic [CHAR_W-1:0]      mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    logic                   push_c;
    logic                   pop_c;
    logic                   wr_en_c;
    logic [PTR_W-1:0]       wr_ptr_nxt;
    logic [PTR_W-1:0]       rd_ptr_nxt;
    logic [CNT_W-1:0]       count_nxt;
    logic                   overflow_nxt;

    // Strobe synchroniser with a parallel data pipe of equal depth so the
    // code arrives aligned with its strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_sync <= '0;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                d_sync[i] <= '0;
            end
        end else begin
            s_sync    <= {s_sync[SYNC_STAGES-2:0], strobe_in};
            d_sync[0] <= char_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                d_sync[i] <= d_sync[i-1];
            end
        end
    end

    // Edge register only advances while enabled, so an edge completed during
    // ena=0 is still detected once ena returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_prev <= 1'b0;
        end else if (ena) begin
            s_prev <= s_sync[SYNC_STAGES-1];
        end
    end

    assign push_c = ena & s_sync[SYNC_STAGES-1] & ~s_prev;
    assign pop_c  = ena & out_valid & out_ready;

    // Next-state for pointers, occupancy and overflow.
    always_comb begin
        wr_en_c      = 1'b0;
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        count_nxt    = count;
        overflow_nxt = overflow;
        if (push_c && pop_c) begin
            wr_en_c    = 1'b1;
            wr_ptr_nxt = wr_ptr + PTR_W'(1);
            rd_ptr_nxt = rd_ptr + PTR_W'(1);
        end else if (push_c && !full) begin
            wr_en_c    = 1'b1;
            wr_ptr_nxt = wr_ptr + PTR_W'(1);
            count_nxt  = count + CNT_W'(1);
        end else if (push_c) begin
            overflow_nxt = 1'b1;
`ifdef CHAR_QUEUE_OVERWRITE_EN
            // Keep the newest DEPTH characters: replace the oldest one.
            wr_en_c    = 1'b1;
            wr_ptr_nxt = wr_ptr + PTR_W'(1);
            rd_ptr_nxt = rd_ptr + PTR_W'(1);
`endif
        end else if (pop_c) begin
            rd_ptr_nxt = rd_ptr + PTR_W'(1);
            count_nxt  = count - CNT_W'(1);
        end
    end

    // Queue state and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            full      <= 1'b0;
            empty     <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            overflow  <= overflow_nxt;
            full      <= (count_nxt == CNT_W'(DEPTH));
            empty     <= (count_nxt == '0);
            out_valid <= (count_nxt != '0);
        end
    end

    // Storage is not reset; contents are don't-care while out_valid is low.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= d_sync[SYNC_STAGES-1];
        end
    end

    assign out_char = mem[rd_ptr];

endmodule

// File: tb/tb_char_input_queue.sv
// Scoreboard bench for char_input_queue: a behavioural model turns sampled
// pin activity into expected queue contents; a negedge monitor compares
// status and pops expected characters whenever the DUT hands one over.
module tb_char_input_queue;

    localparam int DEPTH = 4;
    localparam int CW    = 7;
    localparam int SYNC  = 2;

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic          strobe_in;
    logic [CW-1:0] char_in;
    logic          out_ready;
    logic          out_valid;
    logic [CW-1:0] out_char;
    logic          full;
    logic          empty;
    logic [2:0]    count;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    // model state
    logic [CW-1:0] exp_q [$];
    int            mcnt;
    bit            movf;
    bit            mprev;
    bit            s_hist [$];
    logic [CW-1:0] c_hist [$];

    char_input_queue #(.DEPTH(DEPTH), .CHAR_W(CW), .SYNC_STAGES(SYNC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .strobe_in(strobe_in),
        .char_in  (char_in),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_char (out_char),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a pin sample reaches the edge detector SYNC edges
    // after it was taken; rising edges seen while enabled become pushes.
    initial begin
        bit            sv;
        logic [CW-1:0] sc;
        bit            mpush;
        bit            mpop;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                s_hist.delete();
                c_hist.delete();
                for (int i = 0; i < SYNC; i++) begin
                    s_hist.push_back(1'b0);
                    c_hist.push_back('0);
                end
                mcnt  = 0;
                movf  = 1'b0;
                mprev = 1'b0;
            end else begin
                sv = s_hist.pop_front();
                sc = c_hist.pop_front();
                s_hist.push_back(strobe_in);
                c_hist.push_back(char_in);
                mpush = ena && sv && !mprev;
                if (ena) mprev = sv;
                mpop = ena && out_ready && (mcnt > 0);
                if (mpush && mpop) begin
                    exp_q.push_back(sc);
                end else if (mpush) begin
                    if (mcnt < DEPTH) begin
                        exp_q.push_back(sc);
                        mcnt++;
                    end else begin
                        movf = 1'b1;
`ifdef CHAR_QUEUE_OVERWRITE_EN
                        void'(exp_q.pop_front());
                        exp_q.push_back(sc);
`endif
                    end
                end else if (mpop) begin
                    mcnt--;
                end
            end
        end
    end

    // Monitor: status against the model, data against the scoreboard queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("out_valid", int'(out_valid), int'(mcnt > 0));
                chk("count", int'(count), mcnt);
                chk("full", int'(full), int'(mcnt == DEPTH));
                chk("empty", int'(empty), int'(mcnt == 0));
                chk("overflow", int'(overflow), int'(movf));
                if (out_valid && out_ready && ena) begin
                    if (exp_q.size() == 0) begin
                        chk("pop_with_no_expected_entry", 1, 0);
                    end else begin
                        chk("out_char", int'(out_char), int'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic push_char(input logic [CW-1:0] c);
        strobe_in = 1'b1;
        char_in   = c;
        cyc(1);
        strobe_in = 1'b0;
        cyc(1);
    endtask

    task automatic fill4();
        for (int i = 1; i <= 4; i++) push_char(CW'(i));
        cyc(3);
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        strobe_in = 1'b0;
        char_in   = '0;
        out_ready = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("reset_empty", int'(empty), 1);
        chk("reset_valid", int'(out_valid), 0);

        // single push latency
        strobe_in = 1'b1;
        char_in   = 7'h3F;
        cyc(1);
        chk("lat_edge_k", int'(out_valid), 0);
        strobe_in = 1'b0;
        cyc(1);
        chk("lat_edge_k1", int'(out_valid), 0);
        cyc(1);
        chk("lat_edge_k2", int'(out_valid), 1);
        chk("lat_char", int'(out_char), 'h3F);
        chk("lat_count", int'(count), 1);
        out_ready = 1'b1;
        cyc(3);
        out_ready = 1'b0;

        // fill then drain
        fill4();
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 4);
        out_ready = 1'b1;
        cyc(6);
        chk("drain_empty", int'(empty), 1);
        out_ready = 1'b0;

        // push while full
        do_reset();
        fill4();
        push_char(7'h05);
        cyc(3);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_count", int'(count), 4);
        out_ready = 1'b1;
        cyc(6);
        out_ready = 1'b0;

        // push lands on the same edge as a pop while full
        do_reset();
        fill4();
        strobe_in = 1'b1;
        char_in   = 7'h05;
        cyc(1);
        strobe_in = 1'b0;
        cyc(1);
        out_ready = 1'b1;
        cyc(1);
        chk("pp_count", int'(count), 4);
        chk("pp_ovf", int'(overflow), 0);
        cyc(6);
        out_ready = 1'b0;

        // held strobe, then an edge during ena=0
        do_reset();
        strobe_in = 1'b1;
        char_in   = 7'h11;
        cyc(20);
        strobe_in = 1'b0;
        cyc(4);
        chk("hold_count", int'(count), 1);
        ena       = 1'b0;
        strobe_in = 1'b1;
        char_in   = 7'h22;
        cyc(5);
        chk("ena0_count", int'(count), 1);
        ena = 1'b1;
        cyc(2);
        strobe_in = 1'b0;
        chk("ena1_count", int'(count), 2);
        cyc(3);

        // asynchronous reset with entries queued
        do_reset();
        push_char(7'h0A);
        push_char(7'h0B);
        push_char(7'h0C);
        cyc(3);
        chk("pre_rst_count", int'(count), 3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_count", int'(count), 0);
        chk("arst_ovf", int'(overflow), 0);
        chk("arst_empty", int'(empty), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc(2);

        // randomized traffic, alternating consumer-heavy and producer-heavy
        for (int i = 0; i < 3000; i++) begin
            ena = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 2) == 0) strobe_in = ~strobe_in;
            char_in = CW'($urandom);
            if (((i / 200) % 2) == 0) out_ready = ($urandom_range(0, 3) != 0);
            else                      out_ready = ($urandom_range(0, 3) == 0);
            cyc(1);
        end

        ena       = 1'b1;
        strobe_in = 1'b0;
        out_ready = 1'b1;
        cyc(20);
        chk("final_scoreboard_empty", exp_q.size(), 0);
        chk("final_dut_empty", int'(empty), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
